// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared encodings and state type for the multicycle control unit
// Contents: opcode constants, alu_op / alu_src_b / pc_source encodings, FSM state enum,
//           and a helper that marks the states whose exit retires an instruction.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // alu_op encodings; zero-extended to ALU_OP_W at the output
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_R   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    BRANCH,
    JUMP,
    TRAP
  } state_t;

  // Final step of an instruction. MEM_WR only retires once memory accepts the write,
  // so callers must additionally qualify that state with mem_ready.
  function automatic logic is_final_state(state_t s);
    return (s == MEM_WB) || (s == MEM_WR) || (s == WB_R) || (s == WB_I) ||
           (s == BRANCH) || (s == JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> multicycle datapath bus
// Signals: stall, opcode, mem_ready (datapath -> control);
//          pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_2_reg,
//          reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source (control -> datapath).
// Modports: master = control unit, slave = datapath.
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 2
);

  logic                stall;
  logic [5:0]          opcode;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                mem_2_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_source;

  modport master (
    input  stall, opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output stall, opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

endinterface

// File: rtl/multicycle_control_unit_retire_counter.sv
// rtl/multicycle_control_unit_retire_counter.sv - retired instruction counter
// Ports: clk, arst_n (async active-low), inc (retire this cycle), hold (freeze count),
//        count (CNT_W-bit running total, wraps from all-ones to zero).
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (inc && !hold) begin
      if (count == {CNT_W{1'b1}}) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing MIPS instructions over a shared datapath
// Ports: clk, arst_n (async active-low), bus (multicycle_control_unit_if.master),
//        illegal_op (one-cycle pulse on undecodable opcode), halted (trap active),
//        retire_cnt (retired instruction count).
// Build option: CTRL_ILLEGAL_TRAP_EN - illegal opcode enters TRAP (halted=1) until reset;
//               otherwise it returns to FETCH and halted is tied 0.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          arst_n,
  multicycle_control_unit_if.master     bus,
  output logic                          illegal_op,
  output logic                          halted,
  output logic [CNT_W-1:0]              retire_cnt
);

  state_t     state;
  state_t     state_nxt;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_2_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;
  logic       trap;
  logic       retire_inc;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    alu_op        = ALU_ADD;
    pc_source     = PC_SRC_ALU;
    illegal       = 1'b0;
    trap          = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;

      FETCH: begin
        // PC+4 is computed and loaded in the same cycle the instruction arrives
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        // ALUOut captures the branch target while the opcode is decoded
        alu_src_b = SRC_B_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_R:         state_nxt = EXEC_R;
          OP_ADDI:      state_nxt = EXEC_I;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          default: begin
            illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt = TRAP;
`else
            state_nxt = FETCH;
`endif
          end
        endcase
      end

      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_nxt = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) state_nxt = MEM_WB;
      end

      MEM_WB: begin
        mem_2_reg = 1'b1;
        reg_write = 1'b1;
        state_nxt = FETCH;
      end

      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) state_nxt = FETCH;
      end

      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_R;
        state_nxt = WB_R;
      end

      WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_nxt = FETCH;
      end

      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_nxt = WB_I;
      end

      WB_I: begin
        reg_write = 1'b1;
        state_nxt = FETCH;
      end

      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        state_nxt     = FETCH;
      end

      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        state_nxt = FETCH;
      end

`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: trap = 1'b1;
`endif

      default: state_nxt = IDLE;
    endcase

    // Stall freezes the sequence and blocks every architectural side effect,
    // but leaves the mux selects alone so the datapath keeps a stable view.
    if (bus.stall) begin
      state_nxt     = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal       = 1'b0;
    end

    retire_inc = !bus.stall && is_final_state(state) &&
                 ((state != MEM_WR) || bus.mem_ready);
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.ir_write      = ir_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_2_reg     = mem_2_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = ALU_OP_W'(alu_op);
  assign bus.pc_source     = pc_source;
  assign illegal_op        = illegal;
  assign halted            = trap;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (retire_inc),
    .hold   (bus.stall),
    .count  (retire_cnt)
  );

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction over 3-5 steps (fetch, decode, execute, memory, writeback) on a shared memory/ALU datapath.
- Waits on a memory ready handshake, honours a pipeline stall, flags illegal opcodes and counts retired instructions.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- ALU_OP_W, 2, width of alu_op; must be >=2; encodings zero-extended.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold current state; suppress all write enables.
- opcode  in  6  instruction[31:26] from instruction register.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  instruction register load.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_2_reg  out  1  writeback select: 1=MDR, 0=ALUOut.
- reg_dst  out  1  destination register: 1=rd, 0=rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- alu_op  out  ALU_OP_W  0=ADD, 1=SUB, 2=R-type (funct decode).
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on undecodable opcode.
- halted  out  1  trap state active (optional feature only; otherwise tied 0).
- retire_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Reset (async, arst_n=0): state=IDLE; every output 0; retire_cnt=0. Outputs are a pure decode of state (plus mem_ready/stall gating), so all outputs are 0 while in IDLE.
- Opcodes: R=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B.
- IDLE: all outputs 0; next state FETCH unconditionally. This gives one idle cycle after reset release.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write and pc_write are asserted only while mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target precompute). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R -> EXEC_R
  - ADDI -> EXEC_I
  - BEQ -> BRANCH
  - J -> JUMP
  - any other opcode: illegal_op=1 and next state FETCH; the instruction is not retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready=1, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=R. Next state WB_R.
- WB_R: reg_dst=1, reg_write=1. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state WB_I.
- WB_I: reg_dst=0, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- Retire: retire_cnt increments by 1 on the clock edge leaving MEM_WB, MEM_WR, WB_R, WB_I, BRANCH or JUMP. It wraps to 0 at 2^CNT_W-1.
- Stall:
  - While stall=1, the state holds.
  - pc_write, pc_write_cond, ir_write, reg_write, mem_write and illegal_op are forced to 0. Other outputs keep their state decode.
  - retire_cnt holds.
- Stall has priority over mem_ready: if stall=1 and mem_ready=1 in the same cycle, no transition occurs and ir_write stays 0.
- Reset mid-instruction: immediate return to IDLE. Any partial memory access is abandoned and no retire is counted.
- Every cycle count excludes stall cycles and assumes mem_ready=1 throughout:
  - LW = 5 cycles
  - SW, R, ADDI = 4 cycles
  - BEQ, J = 3 cycles
  - illegal opcode = 2 cycles

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE pulses illegal_op and transitions to TRAP. In TRAP, all outputs are 0 except halted=1. TRAP exits only via reset.
- Undefined: no TRAP state; an illegal opcode returns to FETCH; halted is tied 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants
  - alu_op encodings (ADD/SUB/R)
  - alu_src_b and pc_source encodings
  - state enum (IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, TRAP).
- Sub-module retire_counter (CNT_W, inc, hold, wrap) holds the counter. The FSM and output decode stay in the top module.

Test Plan:
- Reset release with opcode=0x00 and mem_ready=1 -> cycle 0 all outputs 0 (IDLE); FETCH asserts mem_read, ir_write and pc_write; DECODE; EXEC_R shows alu_op=2; WB_R shows reg_write=1, reg_dst=1; retire_cnt=1.
- LW (0x23) with mem_ready held low for 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held for 4 cycles; then MEM_WB with mem_2_reg=1, reg_write=1, reg_dst=0; total 8 cycles.
- BEQ (0x04) -> BRANCH cycle has pc_write_cond=1, pc_source=01, alu_op=1; J (0x02) -> JUMP cycle has pc_write=1, pc_source=10; retire_cnt +2.
- stall=1 for 2 cycles during WB_I of ADDI (0x08) -> reg_write=0 and state held during the stall; reg_write=1 on the first unstalled cycle; exactly one retire.
- opcode=0x3F in DECODE -> illegal_op pulses 1 cycle; without the macro, next state FETCH and retire_cnt unchanged; with CTRL_ILLEGAL_TRAP_EN, halted=1 and all other outputs 0 until arst_n=0.
- CNT_W=4, 16 back-to-back R-type instructions -> retire_cnt wraps 15 -> 0; arst_n asserted mid-MEM_WR -> mem_write drops to 0 immediately (asynchronously) and state returns to IDLE.
